// File: rtl/pkt_stream_fifo_pkg.sv
// Shared types and defaults for the DSP-domain packet FIFO.
package pkt_stream_fifo_pkg;

    localparam int PKT_WIDTH  = 16;
    localparam int FIFO_DEPTH = 16;

    typedef logic [PKT_WIDTH-1:0] pkt_t;

endpackage

// File: rtl/pkt_stream_fifo_if.sv
// Packet stream bundle between producer/consumer and the FIFO.
interface pkt_stream_fifo_if #(
    parameter int PKT_WIDTH = pkt_stream_fifo_pkg::PKT_WIDTH
);

    logic [PKT_WIDTH-1:0] pkt_i;
    logic                 pktChanged_i;
    logic                 rdEN_i;
    logic [PKT_WIDTH-1:0] pktOut_s_o;
    logic                 pktOutChanged_c_o;
    logic                 full_o;
    logic                 empty_o;
    logic                 overflow_o;

    modport master (
        output pkt_i,
        output pktChanged_i,
        output rdEN_i,
        input  pktOut_s_o,
        input  pktOutChanged_c_o,
        input  full_o,
        input  empty_o,
        input  overflow_o
    );

    modport slave (
        input  pkt_i,
        input  pktChanged_i,
        input  rdEN_i,
        output pktOut_s_o,
        output pktOutChanged_c_o,
        output full_o,
        output empty_o,
        output overflow_o
    );

endinterface

// File: rtl/pkt_fifo_mem.sv
// Simple dual-port register array: synchronous write, asynchronous read.
module pkt_fifo_mem #(
    parameter int WIDTH = 16,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/pkt_stream_fifo.sv
// Single-clock packet FIFO releasing 16-bit packets to the DSP pipeline
// with a one-cycle new-packet flag.
module pkt_stream_fifo
    import pkt_stream_fifo_pkg::*;
#(
    parameter int PKT_WIDTH = pkt_stream_fifo_pkg::PKT_WIDTH,
    parameter int DEPTH     = FIFO_DEPTH
) (
    input  logic              clkDSP_i,
    input  logic              rstDSP_i,
    pkt_stream_fifo_if.slave  bus
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [AW:0]          count;
    logic [PKT_WIDTH-1:0] pkt_out;
    logic [PKT_WIDTH-1:0] rd_data;
    logic                 pop_done;
    logic                 overflow;
    logic                 full;
    logic                 empty;
    logic                 do_pop;
    logic                 do_wr;

    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);

    // A pop frees a slot on the same edge, so a full FIFO still accepts.
    assign do_pop = bus.rdEN_i & ~empty;
    assign do_wr  = bus.pktChanged_i & (~full | do_pop);

    pkt_fifo_mem #(
        .WIDTH (PKT_WIDTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clkDSP_i),
        .we    (do_wr),
        .waddr (wr_ptr),
        .wdata (bus.pkt_i),
        .raddr (rd_ptr),
        .rdata (rd_data)
    );

    always_ff @(posedge clkDSP_i) begin
        if (rstDSP_i) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            pkt_out  <= '0;
            pop_done <= 1'b0;
            overflow <= 1'b0;
        end else begin
            pop_done <= do_pop;
            if (do_wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr  <= rd_ptr + 1'b1;
                pkt_out <= rd_data;
            end
            if (bus.pktChanged_i & ~do_wr) begin
                overflow <= 1'b1;
            end
            unique case ({do_wr, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign bus.pktOut_s_o        = pkt_out;
    assign bus.pktOutChanged_c_o = pop_done & ~rstDSP_i;
    assign bus.full_o            = full;
    assign bus.empty_o           = empty;
    assign bus.overflow_o        = overflow;

endmodule

// File: tb/tb_pkt_stream_fifo.sv
// Scoreboard bench for pkt_stream_fifo.
module tb_pkt_stream_fifo;

    logic clk;
    logic rst;

    int n_run;
    int n_fail;
    int pulses;
    int p0;

    logic [15:0] exp_q [$];
    logic [15:0] e;

    pkt_stream_fifo_if #(.PKT_WIDTH(16)) bus ();

    pkt_stream_fifo #(
        .PKT_WIDTH (16),
        .DEPTH     (16)
    ) dut (
        .clkDSP_i (clk),
        .rstDSP_i (rst),
        .bus      (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        n_run++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        bus.pktChanged_i = 1'b0;
        repeat (cycles) tick();
        rst = 1'b0;
        exp_q.delete();
    endtask

    task automatic wr1(input logic [15:0] d, input bit push);
        bus.pkt_i = d;
        bus.pktChanged_i = 1'b1;
        if (push) exp_q.push_back(d);
        tick();
        bus.pktChanged_i = 1'b0;
    endtask

    always @(negedge clk) begin
        if (bus.pktOutChanged_c_o) begin
            pulses++;
            if (exp_q.size() == 0) begin
                chk("spurious", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("data", {16'h0, bus.pktOut_s_o}, {16'h0, e});
            end
        end
    end

    initial begin
        n_run = 0;
        n_fail = 0;
        pulses = 0;
        rst = 1'b1;
        bus.pkt_i = '0;
        bus.pktChanged_i = 1'b0;
        bus.rdEN_i = 1'b1;
        do_reset(2);

        chk("rst_out", bus.pktOut_s_o, 0);
        chk("rst_chg", bus.pktOutChanged_c_o, 0);
        chk("rst_empty", bus.empty_o, 1);
        chk("rst_full", bus.full_o, 0);
        chk("rst_ovf", bus.overflow_o, 0);

        // single packet, latency check
        p0 = pulses;
        wr1(16'h0001, 1'b1);
        tick();
        chk("single_out", bus.pktOut_s_o, 16'h0001);
        chk("single_chg", bus.pktOutChanged_c_o, 1);
        tick();
        chk("single_chg_off", bus.pktOutChanged_c_o, 0);
        chk("single_empty", bus.empty_o, 1);
        repeat (3) tick();
        chk("single_pulses", pulses - p0, 1);

        // gapped writes straight after reset release
        do_reset(1);
        p0 = pulses;
        wr1(16'hAAAA, 1'b1);
        repeat (2) tick();
        wr1(16'hBBBB, 1'b1);
        tick();
        wr1(16'hCCCC, 1'b1);
        repeat (3) tick();
        wr1(16'hDDDD, 1'b1);
        repeat (4) tick();
        chk("gap_pulses", pulses - p0, 4);
        chk("gap_ovf", bus.overflow_o, 0);
        chk("gap_q", exp_q.size(), 0);

        // back-to-back strobes
        p0 = pulses;
        for (int i = 0; i < 6; i++) begin
            bus.pkt_i = 16'hAAAA + 16'(i) * 16'h1111;
            bus.pktChanged_i = 1'b1;
            exp_q.push_back(bus.pkt_i);
            tick();
            chk("b2b_cnt", 32'(dut.count <= 1), 1);
        end
        bus.pktChanged_i = 1'b0;
        repeat (4) tick();
        chk("b2b_pulses", pulses - p0, 6);

        // fill and overflow
        bus.rdEN_i = 1'b0;
        for (int i = 0; i < 17; i++) begin
            wr1(16'h100A + 16'(i), i < 16);
            if (i == 15) begin
                chk("fill_full", bus.full_o, 1);
                chk("fill_ovf0", bus.overflow_o, 0);
            end
        end
        chk("fill_ovf1", bus.overflow_o, 1);
        p0 = pulses;
        bus.rdEN_i = 1'b1;
        repeat (22) tick();
        chk("drain_pulses", pulses - p0, 16);
        chk("drain_empty", bus.empty_o, 1);
        chk("ovf_sticky", bus.overflow_o, 1);

        // full with simultaneous write and pop
        do_reset(1);
        bus.rdEN_i = 1'b0;
        for (int i = 0; i < 16; i++) begin
            wr1(16'h2000 + 16'(i), 1'b1);
        end
        chk("sim_full", bus.full_o, 1);
        p0 = pulses;
        bus.rdEN_i = 1'b1;
        wr1(16'h1234, 1'b1);
        chk("sim_ovf", bus.overflow_o, 0);
        chk("sim_cnt", 32'(dut.count), 16);
        repeat (22) tick();
        chk("sim_pulses", pulses - p0, 17);
        chk("sim_q", exp_q.size(), 0);

        // reset mid-operation
        bus.rdEN_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            wr1(16'h3000 + 16'(i), 1'b0);
        end
        bus.pkt_i = 16'hFFFF;
        bus.pktChanged_i = 1'b1;
        tick();
        bus.pktChanged_i = 1'b0;
        chk("mid_pre_full", bus.empty_o, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_empty", bus.empty_o, 1);
        chk("mid_out", bus.pktOut_s_o, 0);
        chk("mid_ovf", bus.overflow_o, 0);
        p0 = pulses;
        bus.rdEN_i = 1'b1;
        repeat (10) tick();
        chk("mid_pulses", pulses - p0, 0);
        chk("mid_out2", bus.pktOut_s_o, 0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
